// File: rtl/veldt_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : veldt_mem_ctrl_if
// Brief    : Veldt core native memory port (valid/ready request, one-cycle
//            completion pulse with read data).
// Revision : 1.0
// ============================================================================
interface veldt_mem_ctrl_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/veldt_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : veldt_mem_ctrl
// Brief    : Veldt memory-port slave onto a 1-cycle-latency word SRAM, with
//            programmable wait states and fault response for bad addresses.
// Revision : 1.0
// ============================================================================
module veldt_mem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [31:0] FAULT_DATA  = 32'hDEAD_BEEF
) (
    input  logic                  clock,
    input  logic                  reset,
    veldt_mem_ctrl_if.slave       mem,
    output logic                  sram_en,
    output logic [3:0]            sram_we,
    output logic [ADDR_WIDTH-1:0] sram_addr,
    output logic [31:0]           sram_wdata,
    input  logic [31:0]           sram_rdata,
    output logic                  bus_fault,
    output logic                  fault_sticky,
    output logic                  last_fault_instr
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WAIT   = 3'd1,
        S_ACCESS = 3'd2,
        S_DATA   = 3'd3,
        S_RESP   = 3'd4
    } t_state;

    localparam logic [3:0]  c_WAIT_INIT = 4'(WAIT_STATES);
    localparam logic [30:0] c_WINDOW    = 31'(1) << ADDR_WIDTH;

    t_state                r_state;
    logic [3:0]            r_wait_cnt;
    logic [ADDR_WIDTH-1:0] r_addr_off;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;

    logic                  r_mem_ready;
    logic [31:0]           r_mem_rdata;
    logic                  r_sram_en;
    logic [3:0]            r_sram_we;
    logic [ADDR_WIDTH-1:0] r_sram_addr;
    logic [31:0]           r_sram_wdata;
    logic                  r_bus_fault;
    logic                  r_fault_sticky;
    logic                  r_last_fault_instr;

    // Unsigned 30-bit difference: addresses below BASE wrap to huge offsets.
    logic [29:0] w_word_off;
    logic        w_fault;

    assign w_word_off = mem.mem_addr[31:2] - BASE_ADDR[31:2];
    assign w_fault    = (mem.mem_addr[1:0] != 2'b00) || ({1'b0, w_word_off} >= c_WINDOW);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state            <= S_IDLE;
            r_wait_cnt         <= '0;
            r_addr_off         <= '0;
            r_wdata            <= '0;
            r_wstrb            <= '0;
            r_mem_ready        <= 1'b0;
            r_mem_rdata        <= '0;
            r_sram_en          <= 1'b0;
            r_sram_we          <= '0;
            r_sram_addr        <= '0;
            r_sram_wdata       <= '0;
            r_bus_fault        <= 1'b0;
            r_fault_sticky     <= 1'b0;
            r_last_fault_instr <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises only what it owns.
            r_mem_ready  <= 1'b0;
            r_mem_rdata  <= '0;
            r_bus_fault  <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= '0;
            r_sram_addr  <= '0;
            r_sram_wdata <= '0;

            case (r_state)
                S_IDLE: begin
                    if (mem.mem_valid) begin
                        r_addr_off <= w_word_off[ADDR_WIDTH-1:0];
                        r_wdata    <= mem.mem_wdata;
                        r_wstrb    <= mem.mem_wstrb;
                        if (w_fault) begin
                            r_state            <= S_RESP;
                            r_mem_ready        <= 1'b1;
                            r_mem_rdata        <= (mem.mem_wstrb == 4'b0000) ? FAULT_DATA : 32'h0;
                            r_bus_fault        <= 1'b1;
                            r_fault_sticky     <= 1'b1;
                            r_last_fault_instr <= mem.mem_instr;
                        end else if (c_WAIT_INIT == 4'd0) begin
                            r_state      <= S_ACCESS;
                            r_sram_en    <= 1'b1;
                            r_sram_we    <= mem.mem_wstrb;
                            r_sram_addr  <= w_word_off[ADDR_WIDTH-1:0];
                            r_sram_wdata <= mem.mem_wdata;
                        end else begin
                            r_state    <= S_WAIT;
                            r_wait_cnt <= c_WAIT_INIT;
                        end
                    end
                end

                S_WAIT: begin
                    r_wait_cnt <= r_wait_cnt - 4'd1;
                    if (r_wait_cnt == 4'd1) begin
                        r_state      <= S_ACCESS;
                        r_sram_en    <= 1'b1;
                        r_sram_we    <= r_wstrb;
                        r_sram_addr  <= r_addr_off;
                        r_sram_wdata <= r_wdata;
                    end
                end

                S_ACCESS: begin
                    if (r_wstrb != 4'b0000) begin
                        r_state     <= S_RESP;
                        r_mem_ready <= 1'b1;
                    end else begin
                        r_state <= S_DATA;
                    end
                end

                S_DATA: begin
                    r_state     <= S_RESP;
                    r_mem_ready <= 1'b1;
                    r_mem_rdata <= sram_rdata;
                end

                S_RESP: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_ready    = r_mem_ready;
    assign mem.mem_rdata    = r_mem_rdata;
    assign sram_en          = r_sram_en;
    assign sram_we          = r_sram_we;
    assign sram_addr        = r_sram_addr;
    assign sram_wdata       = r_sram_wdata;
    assign bus_fault        = r_bus_fault;
    assign fault_sticky     = r_fault_sticky;
    assign last_fault_instr = r_last_fault_instr;

endmodule
`default_nettype wire

// File: tb/tb_veldt_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_veldt_mem_ctrl
// Brief    : Self-checking bench: two controller instances (no-wait/BASE 0 and
//            3-wait/BASE 0x100), each with its own behavioural SRAM.
// Revision : 1.0
// ============================================================================
module tb_veldt_mem_ctrl;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        flt;
        int          lat;
    } exp_t;
    exp_t q_exp[$];

    logic        tb_valid [2];
    logic        tb_instr [2];
    logic [31:0] tb_addr  [2];
    logic [31:0] tb_wdata [2];
    logic [3:0]  tb_wstrb [2];

    veldt_mem_ctrl_if if0();
    veldt_mem_ctrl_if if1();

    assign if0.mem_valid = tb_valid[0];
    assign if0.mem_instr = tb_instr[0];
    assign if0.mem_addr  = tb_addr[0];
    assign if0.mem_wdata = tb_wdata[0];
    assign if0.mem_wstrb = tb_wstrb[0];
    assign if1.mem_valid = tb_valid[1];
    assign if1.mem_instr = tb_instr[1];
    assign if1.mem_addr  = tb_addr[1];
    assign if1.mem_wdata = tb_wdata[1];
    assign if1.mem_wstrb = tb_wstrb[1];

    logic        en0, en1, bf0, bf1, fs0, fs1, lfi0, lfi1;
    logic [3:0]  we0, we1;
    logic [9:0]  sa0, sa1;
    logic [31:0] wd0, wd1, rd0, rd1;

    veldt_mem_ctrl #(
        .BASE_ADDR(32'h0000_0000), .ADDR_WIDTH(10), .WAIT_STATES(0), .FAULT_DATA(32'hDEAD_BEEF)
    ) dut0 (
        .clock(clock), .reset(reset), .mem(if0),
        .sram_en(en0), .sram_we(we0), .sram_addr(sa0), .sram_wdata(wd0), .sram_rdata(rd0),
        .bus_fault(bf0), .fault_sticky(fs0), .last_fault_instr(lfi0)
    );

    veldt_mem_ctrl #(
        .BASE_ADDR(32'h0000_0100), .ADDR_WIDTH(10), .WAIT_STATES(3), .FAULT_DATA(32'hDEAD_BEEF)
    ) dut1 (
        .clock(clock), .reset(reset), .mem(if1),
        .sram_en(en1), .sram_we(we1), .sram_addr(sa1), .sram_wdata(wd1), .sram_rdata(rd1),
        .bus_fault(bf1), .fault_sticky(fs1), .last_fault_instr(lfi1)
    );

    // Behavioural SRAMs: byte-lane writes, registered read data.
    logic [31:0] sram0 [0:1023];
    logic [31:0] sram1 [0:1023];
    logic [31:0] sh0   [0:1023];

    always @(posedge clock) begin
        if (en0) begin
            for (int b = 0; b < 4; b++)
                if (we0[b]) sram0[sa0][b*8 +: 8] <= wd0[b*8 +: 8];
            if (we0 == 4'b0000) rd0 <= sram0[sa0];
        end
        if (en1) begin
            for (int b = 0; b < 4; b++)
                if (we1[b]) sram1[sa1][b*8 +: 8] <= wd1[b*8 +: 8];
            if (we1 == 4'b0000) rd1 <= sram1[sa1];
        end
    end

    function automatic logic [31:0] init_word(input int i);
        return (i == 3) ? 32'h1234_5678 : (32'hA500_0000 | 32'(i));
    endfunction

    // Observation mux for whichever instance the running test drives.
    bit          sel;
    logic        obs_ready, obs_fault, obs_en;
    logic [31:0] obs_rdata, obs_wdata;
    logic [3:0]  obs_we;
    logic [9:0]  obs_addr;

    always_comb begin
        obs_ready = sel ? if1.mem_ready : if0.mem_ready;
        obs_rdata = sel ? if1.mem_rdata : if0.mem_rdata;
        obs_fault = sel ? bf1 : bf0;
        obs_en    = sel ? en1 : en0;
        obs_we    = sel ? we1 : we0;
        obs_addr  = sel ? sa1 : sa0;
        obs_wdata = sel ? wd1 : wd0;
    end

    int          t_lat, t_nen, t_nz;
    logic [31:0] t_rdata, t_wdata;
    logic        t_flt;
    logic [9:0]  t_addr;
    logic [3:0]  t_we;

    // Issue one request (valid for a single sampled edge, then inputs scrambled)
    // and record what the DUT does up to and including the mem_ready cycle.
    task automatic run_txn(input bit s, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] st, input logic ins);
        sel = s;
        @(negedge clock);
        tb_valid[s] = 1'b1; tb_addr[s] = a; tb_wdata[s] = wd; tb_wstrb[s] = st; tb_instr[s] = ins;
        @(negedge clock);
        tb_valid[s] = 1'b0; tb_addr[s] = 32'hFFFF_FFF3; tb_wdata[s] = 32'h0BAD_0BAD;
        tb_wstrb[s] = 4'hF; tb_instr[s] = ~ins;
        t_lat = 1; t_nen = 0; t_nz = 0; t_addr = '0; t_we = '0; t_wdata = '0;
        while (!obs_ready && t_lat < 40) begin
            if (obs_en) begin
                t_nen++; t_addr = obs_addr; t_we = obs_we; t_wdata = obs_wdata;
            end
            if (obs_rdata !== 32'h0) t_nz++;
            @(negedge clock);
            t_lat++;
        end
        if (obs_en) t_nen++;
        t_rdata = obs_rdata;
        t_flt   = obs_fault;
    endtask

    task automatic test_reset();
        checks++;
        if ({if0.mem_ready, if0.mem_rdata, en0, we0, sa0, wd0, bf0, fs0, lfi0} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_dut0 got %h want 0",
                     {if0.mem_ready, if0.mem_rdata, en0, we0, sa0, wd0, bf0, fs0, lfi0});
        end
        checks++;
        if ({if1.mem_ready, if1.mem_rdata, en1, we1, sa1, wd1, bf1, fs1, lfi1} !== '0) begin
            errors++;
            $display("FAIL reset_outputs_dut1 got %h want 0",
                     {if1.mem_ready, if1.mem_rdata, en1, we1, sa1, wd1, bf1, fs1, lfi1});
        end
    endtask

    task automatic test_read();
        exp_t e;
        q_exp.push_back('{32'h1234_5678, 1'b0, 3});
        run_txn(1'b0, 32'h0000_000C, 32'h0, 4'b0000, 1'b1);
        e = q_exp.pop_front();
        checks++; if (t_lat !== e.lat) begin errors++; $display("FAIL read_latency got %0d want %0d", t_lat, e.lat); end
        checks++; if (t_rdata !== e.rdata) begin errors++; $display("FAIL read_data got %h want %h", t_rdata, e.rdata); end
        checks++; if (t_flt !== e.flt) begin errors++; $display("FAIL read_bus_fault got %b want %b", t_flt, e.flt); end
        checks++; if (t_nen !== 1) begin errors++; $display("FAIL read_sram_en_count got %0d want 1", t_nen); end
        checks++; if (t_addr !== 10'd3 || t_we !== 4'b0000) begin
            errors++; $display("FAIL read_sram_addr_we got %0d/%b want 3/0000", t_addr, t_we); end
        checks++; if (t_nz !== 0) begin errors++; $display("FAIL read_rdata_outside_resp got %0d want 0", t_nz); end
        checks++; if (fs0 !== 1'b0) begin errors++; $display("FAIL read_fault_sticky got %b want 0", fs0); end
    endtask

    task automatic test_write();
        exp_t e;
        q_exp.push_back('{32'h0, 1'b0, 2});
        run_txn(1'b0, 32'h0000_0010, 32'h00AB_0000, 4'b0100, 1'b0);
        e = q_exp.pop_front();
        checks++; if (t_lat !== e.lat) begin errors++; $display("FAIL write_latency got %0d want %0d", t_lat, e.lat); end
        checks++; if (t_rdata !== e.rdata || t_flt !== e.flt) begin
            errors++; $display("FAIL write_resp got %h/%b want %h/%b", t_rdata, t_flt, e.rdata, e.flt); end
        checks++; if (t_nen !== 1 || t_addr !== 10'd4 || t_we !== 4'b0100 || t_wdata !== 32'h00AB_0000) begin
            errors++; $display("FAIL write_sram_access got n=%0d a=%0d we=%b d=%h want n=1 a=4 we=0100 d=00ab0000",
                               t_nen, t_addr, t_we, t_wdata); end
        sh0[4][23:16] = 8'hAB;
        // Read back: only lane 2 of word 4 may have changed.
        q_exp.push_back('{sh0[4], 1'b0, 3});
        run_txn(1'b0, 32'h0000_0010, 32'h0, 4'b0000, 1'b0);
        e = q_exp.pop_front();
        checks++; if (t_rdata !== e.rdata) begin errors++; $display("FAIL partial_write_readback got %h want %h", t_rdata, e.rdata); end
    endtask

    task automatic test_boundary();
        exp_t e;
        q_exp.push_back('{init_word(1023), 1'b0, 3});
        run_txn(1'b0, 32'h0000_0FFC, 32'h0, 4'b0000, 1'b0);
        e = q_exp.pop_front();
        checks++; if (t_rdata !== e.rdata || t_flt !== e.flt || t_lat !== e.lat || t_addr !== 10'd1023) begin
            errors++; $display("FAIL last_word_read got d=%h f=%b l=%0d a=%0d want d=%h f=0 l=3 a=1023",
                               t_rdata, t_flt, t_lat, t_addr, e.rdata); end
    endtask

    task automatic test_fault();
        exp_t e;
        q_exp.push_back('{32'hDEAD_BEEF, 1'b1, 1});
        run_txn(1'b0, 32'h0000_0002, 32'h0, 4'b0000, 1'b1);
        e = q_exp.pop_front();
        checks++; if (t_lat !== e.lat || t_rdata !== e.rdata || t_flt !== e.flt) begin
            errors++; $display("FAIL misaligned_resp got l=%0d d=%h f=%b want l=%0d d=%h f=%b",
                               t_lat, t_rdata, t_flt, e.lat, e.rdata, e.flt); end
        checks++; if (t_nen !== 0) begin errors++; $display("FAIL misaligned_sram_en got %0d want 0", t_nen); end
        checks++; if (fs0 !== 1'b1 || lfi0 !== 1'b1) begin
            errors++; $display("FAIL misaligned_flags got sticky=%b instr=%b want 1/1", fs0, lfi0); end
        @(negedge clock);
        checks++; if (bf0 !== 1'b0 || if0.mem_ready !== 1'b0 || if0.mem_rdata !== 32'h0) begin
            errors++; $display("FAIL fault_pulse_width got bf=%b rdy=%b d=%h want 0/0/0", bf0, if0.mem_ready, if0.mem_rdata); end

        q_exp.push_back('{32'hDEAD_BEEF, 1'b1, 1});
        run_txn(1'b0, 32'h0000_1000, 32'h0, 4'b0000, 1'b0);
        e = q_exp.pop_front();
        checks++; if (t_lat !== e.lat || t_rdata !== e.rdata || t_flt !== e.flt || t_nen !== 0) begin
            errors++; $display("FAIL out_of_range_resp got l=%0d d=%h f=%b n=%0d want l=1 d=%h f=1 n=0",
                               t_lat, t_rdata, t_flt, t_nen, e.rdata); end
        checks++; if (lfi0 !== 1'b0 || fs0 !== 1'b1) begin
            errors++; $display("FAIL out_of_range_flags got instr=%b sticky=%b want 0/1", lfi0, fs0); end

        q_exp.push_back('{32'h0, 1'b1, 1});
        run_txn(1'b0, 32'h0000_1004, 32'hFFFF_FFFF, 4'b1111, 1'b0);
        e = q_exp.pop_front();
        checks++; if (t_lat !== e.lat || t_rdata !== e.rdata || t_flt !== e.flt || t_nen !== 0) begin
            errors++; $display("FAIL fault_write got l=%0d d=%h f=%b n=%0d want l=1 d=0 f=1 n=0",
                               t_lat, t_rdata, t_flt, t_nen); end
    endtask

    task automatic test_wait_states();
        exp_t e;
        q_exp.push_back('{32'h1234_5678, 1'b0, 6});
        run_txn(1'b1, 32'h0000_010C, 32'h0, 4'b0000, 1'b0);
        e = q_exp.pop_front();
        checks++; if (t_lat !== e.lat) begin errors++; $display("FAIL wait_latency got %0d want %0d", t_lat, e.lat); end
        checks++; if (t_rdata !== e.rdata || t_flt !== e.flt) begin
            errors++; $display("FAIL wait_read_data got %h/%b want %h/0", t_rdata, t_flt, e.rdata); end
        checks++; if (t_nen !== 1 || t_addr !== 10'd3) begin
            errors++; $display("FAIL wait_sram_access got n=%0d a=%0d want n=1 a=3", t_nen, t_addr); end
        checks++; if (t_nz !== 0) begin errors++; $display("FAIL wait_rdata_outside_resp got %0d want 0", t_nz); end
        q_exp.push_back('{init_word(1023), 1'b0, 6});
        run_txn(1'b1, 32'h0000_10FC, 32'h0, 4'b0000, 1'b0);
        e = q_exp.pop_front();
        checks++; if (t_rdata !== e.rdata || t_lat !== e.lat || t_flt !== e.flt) begin
            errors++; $display("FAIL based_last_word got d=%h l=%0d f=%b want d=%h l=6 f=0", t_rdata, t_lat, t_flt, e.rdata); end
    endtask

    task automatic test_wrap_fault();
        exp_t e;
        q_exp.push_back('{32'hDEAD_BEEF, 1'b1, 1});
        run_txn(1'b1, 32'h0000_0000, 32'h0, 4'b0000, 1'b1);
        e = q_exp.pop_front();
        checks++; if (t_lat !== e.lat || t_rdata !== e.rdata || t_flt !== e.flt || t_nen !== 0) begin
            errors++; $display("FAIL below_base_resp got l=%0d d=%h f=%b n=%0d want l=1 d=%h f=1 n=0",
                               t_lat, t_rdata, t_flt, t_nen, e.rdata); end
        checks++; if (fs1 !== 1'b1 || lfi1 !== 1'b1) begin
            errors++; $display("FAIL below_base_flags got sticky=%b instr=%b want 1/1", fs1, lfi1); end
        q_exp.push_back('{32'hDEAD_BEEF, 1'b1, 1});
        run_txn(1'b1, 32'h0000_1100, 32'h0, 4'b0000, 1'b0);
        e = q_exp.pop_front();
        checks++; if (t_lat !== e.lat || t_rdata !== e.rdata || t_flt !== e.flt) begin
            errors++; $display("FAIL above_window_resp got l=%0d d=%h f=%b want l=1 d=%h f=1",
                               t_lat, t_rdata, t_flt, e.rdata); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] addrs [3];
        exp_t        e;
        int          k, gap, cyc;
        addrs[0] = 32'h0000_000C; addrs[1] = 32'h0000_0014; addrs[2] = 32'h0000_0FFC;
        q_exp.push_back('{init_word(3), 1'b0, 3});
        q_exp.push_back('{init_word(5), 1'b0, 3});
        q_exp.push_back('{init_word(1023), 1'b0, 3});
        sel = 1'b0;
        @(negedge clock);
        tb_valid[0] = 1'b1; tb_addr[0] = addrs[0]; tb_wstrb[0] = 4'b0000; tb_instr[0] = 1'b0;
        k = 0; gap = 0; cyc = 0;
        while (k < 3 && cyc < 60) begin
            @(negedge clock);
            cyc++;
            if (if0.mem_ready) begin
                e = q_exp.pop_front();
                checks++; if (if0.mem_rdata !== e.rdata) begin
                    errors++; $display("FAIL b2b_data_%0d got %h want %h", k, if0.mem_rdata, e.rdata); end
                if (k > 0) begin
                    checks++; if (gap !== 3) begin
                        errors++; $display("FAIL b2b_gap_%0d got %0d want 3", k, gap); end
                end
                k++; gap = 0;
                if (k < 3) tb_addr[0] = addrs[k];
                else tb_valid[0] = 1'b0;
            end else begin
                gap++;
            end
        end
        tb_valid[0] = 1'b0;
        checks++; if (k !== 3) begin errors++; $display("FAIL b2b_pulse_count got %0d want 3", k); end
        q_exp.delete();
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        int   bad;
        sel = 1'b1;
        @(negedge clock);
        tb_valid[1] = 1'b1; tb_addr[1] = 32'h0000_0120; tb_wdata[1] = 32'h5555_5555;
        tb_wstrb[1] = 4'b1111; tb_instr[1] = 1'b0;
        @(negedge clock);
        tb_valid[1] = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        #1;
        checks++; if (en1 !== 1'b0 || we1 !== 4'b0000 || if1.mem_ready !== 1'b0 || fs1 !== 1'b0) begin
            errors++; $display("FAIL reset_in_wait got en=%b we=%b rdy=%b sticky=%b want 0/0000/0/0",
                               en1, we1, if1.mem_ready, fs1); end
        bad = 0;
        repeat (3) begin
            @(negedge clock);
            if (en1 !== 1'b0 || we1 !== 4'b0000 || if1.mem_ready !== 1'b0) bad++;
        end
        reset = 1'b1;
        repeat (8) begin
            @(negedge clock);
            if (en1 !== 1'b0 || we1 !== 4'b0000 || if1.mem_ready !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL reset_abandons_txn got %0d bad cycles want 0", bad); end
        // Word 8 must still hold its initial value: the aborted write never reached the SRAM.
        q_exp.push_back('{init_word(8), 1'b0, 6});
        run_txn(1'b1, 32'h0000_0120, 32'h0, 4'b0000, 1'b0);
        e = q_exp.pop_front();
        checks++; if (t_rdata !== e.rdata || t_lat !== e.lat || t_flt !== e.flt || fs1 !== 1'b0) begin
            errors++; $display("FAIL read_after_reset got d=%h l=%0d f=%b sticky=%b want d=%h l=6 f=0 sticky=0",
                               t_rdata, t_lat, t_flt, fs1, e.rdata); end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram0[i] = init_word(i);
            sram1[i] = init_word(i);
            sh0[i]   = init_word(i);
        end
        for (int s = 0; s < 2; s++) begin
            tb_valid[s] = 1'b0; tb_instr[s] = 1'b0; tb_addr[s] = '0;
            tb_wdata[s] = '0;   tb_wstrb[s] = '0;
        end
        sel = 1'b0;
        repeat (3) @(negedge clock);
        test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clock);
        test_read();
        test_write();
        test_boundary();
        test_fault();
        test_back_to_back();
        test_wait_states();
        test_wrap_fault();
        test_reset_mid_wait();
        repeat (2) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/veldt_mem_ctrl.md
Name: veldt_mem_ctrl

Overview:
- Memory-side slave for the Veldt core's native memory port (mem_valid/mem_ready handshake). Sits directly downstream of the core.
- Converts each request into a single access on a synchronous single-port word SRAM with 1-cycle read latency.
- Inserts a programmable number of wait states.
- Returns a fault response for misaligned or out-of-range addresses.
- Used both in the simulation top and as a deterministic memory model in formal harnesses.

Parameters:
- BASE_ADDR, 32'h0000_0000: byte address of SRAM word 0; must be word aligned.
- ADDR_WIDTH, 10: SRAM word-address width; window size is 2**ADDR_WIDTH words.
- WAIT_STATES, 0: extra cycles inserted before each SRAM access; legal range 0..15.
- FAULT_DATA, 32'hDEAD_BEEF: value returned on mem_rdata for a faulting read.

Ports:
- clock, in, 1: single clock; all logic on posedge.
- reset, in, 1: asynchronous, active-low reset.
- mem_valid, in, 1: core request valid; held high until mem_ready.
- mem_instr, in, 1: request is an instruction fetch (informational, latched).
- mem_addr, in, 32: byte address.
- mem_wdata, in, 32: write data.
- mem_wstrb, in, 4: byte write enables; 0 = read.
- mem_ready, out, 1: one-cycle completion pulse.
- mem_rdata, out, 32: read data, valid while mem_ready=1.
- sram_en, out, 1: SRAM access enable.
- sram_we, out, 4: SRAM byte write enables.
- sram_addr, out, ADDR_WIDTH: SRAM word address.
- sram_wdata, out, 32: SRAM write data.
- sram_rdata, in, 32: SRAM read data, valid the cycle after sram_en with sram_we=0.
- bus_fault, out, 1: one-cycle pulse, concurrent with mem_ready, on a faulting transaction.
- fault_sticky, out, 1: set on any fault; cleared only by reset.
- last_fault_instr, out, 1: mem_instr value of the most recent faulting request.

Behaviour:
- Reset, asynchronous, reset=0:
  - State goes to IDLE.
  - All outputs are 0, including mem_rdata, sram_* and the fault flags.
  - Wait counter cleared.
  - No SRAM write may occur in or after the cycle reset asserts.
- States are IDLE, WAIT, ACCESS, DATA, RESP.
- IDLE:
  - If mem_valid=1 at the clock edge, latch mem_addr, mem_wdata, mem_wstrb and mem_instr into request registers.
  - Fault check: mem_addr[1:0]!=0, or (mem_addr[31:2]-BASE_ADDR[31:2]) >= 2**ADDR_WIDTH, using unsigned 30-bit subtraction so addresses below BASE wrap and fault.
  - Fault -> RESP with the fault flag set.
  - Else if WAIT_STATES=0 -> ACCESS.
  - Else -> WAIT with counter=WAIT_STATES.
- WAIT: counter decrements each cycle; when counter==1 at the edge -> ACCESS.
- ACCESS:
  - sram_en=1 for exactly one cycle.
  - sram_addr = latched word offset [ADDR_WIDTH-1:0].
  - sram_we = latched wstrb; sram_wdata = latched wdata.
  - Write (wstrb!=0) -> RESP. Read -> DATA.
- DATA: sram_en=0; sram_rdata is captured into the read-data register at the edge; -> RESP.
- RESP:
  - mem_ready=1 for exactly one cycle.
  - mem_rdata:
    - read: the captured data;
    - write: 0;
    - faulting read: FAULT_DATA.
  - On fault: bus_fault=1, fault_sticky set, last_fault_instr updated.
  - -> IDLE.
- mem_rdata is 0 in all cycles other than RESP.
- Latency from mem_valid sampled in IDLE to mem_ready:
  - read: 3+WAIT_STATES cycles;
  - write: 2+WAIT_STATES cycles;
  - fault: 1 cycle.
- Back-to-back requests: the IDLE cycle after RESP samples mem_valid again. There is always at least one idle cycle between mem_ready pulses.
- Inputs are ignored outside IDLE. If mem_valid drops mid-transaction, the transaction still completes and mem_ready still pulses.
- Faulting writes never assert sram_en.
- sram_en is never asserted in any state other than ACCESS.
- Partial writes: only the byte lanes set in wstrb are passed to sram_we; no read-modify-write.

Test Plan:
- Read, WAIT_STATES=0, BASE=0: SRAM word 3 = 32'h1234_5678, mem_addr=32'h0C, wstrb=0 -> sram_en one cycle with sram_addr=3; mem_ready 3 cycles after valid; mem_rdata=32'h1234_5678; bus_fault=0.
- Byte write: mem_addr=32'h10, wstrb=4'b0100, wdata=32'h00AB_0000 -> sram_we=4'b0100, sram_addr=4; mem_ready at cycle 2; mem_rdata=0.
- WAIT_STATES=3 read -> mem_ready at cycle 6; sram_en exactly once.
- Faults:
  - mem_addr=32'h02 (misaligned) -> mem_ready at cycle 1, bus_fault=1, mem_rdata=32'hDEAD_BEEF, no sram_en, fault_sticky=1.
  - ADDR_WIDTH=10, mem_addr=32'h1000 -> same fault response.
  - BASE=32'h100, mem_addr=32'h0 (wraps below BASE) -> same fault response.
- Back-to-back: valid held through three reads -> three mem_ready pulses, each separated by at least one low cycle; data order preserved.
- Reset asserted low in WAIT during a write -> state IDLE immediately, sram_en/sram_we stay 0, mem_ready never pulses, fault_sticky=0; after release, a fresh read completes normally.
